// File: rtl/axi_read_scheduler.sv
// Read-channel scheduler: arbitrates I-cache / D-cache / I-stream bursts onto one AXI AR/R port.
// Define READ_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module axi_read_scheduler #(
  parameter int MASTERS    = 3,
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [MASTERS-1:0]            req_valid,
  input  logic [MASTERS*ADDR_WIDTH-1:0] req_addr,
  input  logic [MASTERS*4-1:0]          req_len,
  output logic [MASTERS-1:0]            req_ready,
  output logic [MASTERS-1:0]            resp_valid,
  output logic [MASTERS-1:0]            resp_last,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic                          ARVALID,
  input  logic                          ARREADY,
  output logic [3:0]                    ARID,
  output logic [3:0]                    ARLEN,
  output logic [ADDR_WIDTH-1:0]         ARADDR,
  input  logic                          RVALID,
  output logic                          RREADY,
  input  logic                          RLAST,
  input  logic [3:0]                    RID,
  input  logic [DATA_WIDTH-1:0]         RDATA,
  output logic                          busy,
  output logic                          proto_err
);

  localparam int IDX_W = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_any;
  logic [3:0]       beat_cnt;
  logic             beat_err;

  // Walk candidates from lowest to highest priority so the last hit wins.
  always_comb begin : arb
    int idx;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
`ifdef READ_ARB_FIXED_PRIO_EN
    for (int i = MASTERS - 1; i >= 0; i--) begin
      idx = i;
      if (req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(idx);
      end
    end
`else
    for (int k = MASTERS; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % MASTERS;
      if (req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(idx);
      end
    end
`endif
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    resp_valid = '0;
    resp_last  = '0;
    ARVALID    = 1'b0;
    RREADY     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          req_ready[grant_idx] = 1'b1;
          state_nxt            = ADDR;
        end
      end
      ADDR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_nxt = DATA;
      end
      DATA: begin
        RREADY = 1'b1;
        // Beats always go to the granted master, even when RID disagrees.
        for (int i = 0; i < MASTERS; i++) begin
          if (ARID == 4'(i)) begin
            resp_valid[i] = RVALID;
            resp_last[i]  = RVALID & RLAST;
          end
        end
        if (RVALID && RLAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    beat_err = 1'b0;
    if (RVALID) begin
      if (state != DATA)
        beat_err = 1'b1;
      else if ((RID != ARID) || (RLAST && (beat_cnt != ARLEN)))
        beat_err = 1'b1;
    end
  end

  assign resp_data = RDATA;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= IDX_W'(MASTERS - 1);
      ARID       <= '0;
      ARLEN      <= '0;
      ARADDR     <= '0;
      beat_cnt   <= '0;
      proto_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant_any) begin
        ARADDR     <= req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
        ARLEN      <= req_len[grant_idx*4 +: 4];
        ARID       <= 4'(grant_idx);
        last_grant <= grant_idx;
        beat_cnt   <= '0;
      end
      if (state == DATA && RVALID) beat_cnt <= beat_cnt + 4'd1;
      if (beat_err) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_read_scheduler.sv
// Randomized self-checking bench for axi_read_scheduler with a rule-level arbitration/beat model.
module tb_axi_read_scheduler;

  localparam int M  = 3;
  localparam int AW = 26;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [M-1:0]    req_valid, req_ready, resp_valid, resp_last;
  logic [M*AW-1:0] req_addr;
  logic [M*4-1:0]  req_len;
  logic [DW-1:0]   resp_data, RDATA;
  logic            ARVALID, ARREADY, RVALID, RREADY, RLAST, busy, proto_err;
  logic [3:0]      ARID, ARLEN, RID;
  logic [AW-1:0]   ARADDR;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          last_g;
  bit          exp_err;
  logic [31:0] data_base;

  axi_read_scheduler #(.MASTERS(M), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_last(resp_last), .resp_data(resp_data),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARLEN(ARLEN), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RID(RID), .RDATA(RDATA),
    .busy(busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arbitration rule: first requester after the previous winner, wrapping.
  function automatic int pick(input int last, input logic [M-1:0] mask);
`ifdef READ_ARB_FIXED_PRIO_EN
    for (int i = 0; i < M; i++)
      if (mask[i]) return i + 0 * last;
`else
    for (int k = 1; k <= M; k++)
      if (mask[(last + k) % M]) return (last + k) % M;
`endif
    return -1;
  endfunction

  task automatic idle_inputs();
    req_valid = '0;
    ARREADY   = 1'b0;
    RVALID    = 1'b0;
    RLAST     = 1'b0;
    RID       = '0;
    RDATA     = '0;
  endtask

  task automatic scramble_addr();
    for (int i = 0; i < M; i++) req_addr[i*AW +: AW] = AW'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    rst_n   = 1'b1;
    last_g  = M - 1;
    exp_err = 1'b0;
    tick();
  endtask

  // One full burst. mode: 0 clean, 1 early RLAST on 2nd beat, 2 wrong RID on 1st beat,
  // 3 reset asserted when the 2nd beat arrives. gaps<0 picks random idle cycles before each beat.
  task automatic burst(input logic [M-1:0] mask, input bit keep, input int arwait,
                       input int gaps, input int mode);
    int            g, gap, b;
    bit            stop;
    logic [AW-1:0] ea;
    logic [3:0]    el;
    req_valid = mask;
    #1;
    g = pick(last_g, mask);
    check("req_ready", 64'(req_ready), 64'(1) << g);
    check("busy_idle", 64'(busy), 64'(0));
    ea = req_addr[g*AW +: AW];
    el = req_len[g*4 +: 4];
    tick();
    last_g = g;
    if (!keep) begin
      req_valid = '0;
      scramble_addr();
    end
    for (int w = 0; w <= arwait; w++) begin
      ARREADY = (w == arwait);
      #1;
      check("arvalid", 64'(ARVALID), 64'(1));
      check("araddr", 64'(ARADDR), 64'(ea));
      check("arlen", 64'(ARLEN), 64'(el));
      check("arid", 64'(ARID), 64'(g));
      check("req_ready_hold", 64'(req_ready), 64'(0));
      check("rready_addr", 64'(RREADY), 64'(0));
      tick();
    end
    ARREADY = 1'b0;
    #1;
    check("arvalid_drop", 64'(ARVALID), 64'(0));
    check("rready_data", 64'(RREADY), 64'(1));
    b    = 0;
    stop = 1'b0;
    while (!stop) begin
      gap = (gaps < 0) ? int'($urandom_range(0, 2)) : ((gaps >> (2 * b)) & 3);
      repeat (gap) begin
        RVALID = 1'b0;
        #1;
        check("gap_quiet", 64'(resp_valid), 64'(0));
        tick();
      end
      RVALID = 1'b1;
      RLAST  = (b == int'(el)) || (mode == 1 && b == 1);
      RID    = (mode == 2 && b == 0) ? (4'(g) ^ 4'd2) : 4'(g);
      RDATA  = data_base + 32'(b);
      if (mode == 3 && b == 1) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_rready", 64'(RREADY), 64'(0));
        check("rst_resp_valid", 64'(resp_valid), 64'(0));
        check("rst_arid", 64'(ARID), 64'(0));
        check("rst_arlen", 64'(ARLEN), 64'(0));
        check("rst_araddr", 64'(ARADDR), 64'(0));
        RVALID = 1'b0;
        RLAST  = 1'b0;
        return;
      end
      #1;
      check("resp_valid", 64'(resp_valid), 64'(1) << g);
      check("resp_last", 64'(resp_last), RLAST ? (64'(1) << g) : 64'(0));
      check("resp_data", 64'(resp_data), 64'(data_base + 32'(b)));
      if (RID != 4'(g) || (RLAST && b != int'(el))) exp_err = 1'b1;
      stop = RLAST;
      tick();
      b++;
    end
    RVALID = 1'b0;
    RLAST  = 1'b0;
    RID    = '0;
    #1;
    check("busy_after", 64'(busy), 64'(0));
    check("rready_after", 64'(RREADY), 64'(0));
    check("proto_err", 64'(proto_err), 64'(exp_err));
  endtask

  initial begin
    rst_n     = 1'b0;
    idle_inputs();
    req_addr  = '0;
    req_len   = '0;
    data_base = 32'h0;
    last_g    = M - 1;
    exp_err   = 1'b0;
    repeat (2) tick();
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_arvalid", 64'(ARVALID), 64'(0));
    check("reset_rready", 64'(RREADY), 64'(0));
    check("reset_req_ready", 64'(req_ready), 64'(0));
    check("reset_proto_err", 64'(proto_err), 64'(0));
    check("reset_arid", 64'(ARID), 64'(0));
    check("reset_araddr", 64'(ARADDR), 64'(0));
    rst_n = 1'b1;
    tick();

    // Single request from master 1.
    req_addr[1*AW +: AW] = 26'h0000400;
    req_len[1*4 +: 4]    = 4'd3;
    data_base            = 32'hA0;
    burst(3'b010, 1'b0, 0, 0, 0);

    // Contention with every master holding its request.
    do_reset();
    req_len = '0;
    for (int i = 0; i < 4; i++) begin
      data_base = $urandom;
      burst(3'b111, 1'b1, 0, -1, 0);
    end
    req_valid = '0;

    // AR backpressure for five cycles.
    scramble_addr();
    req_len[2*4 +: 4] = 4'd2;
    burst(3'b100, 1'b0, 5, 0, 0);

    // R-channel gaps: valid pattern 1,0,0,1,1,0,1.
    req_len[0 +: 4] = 4'd3;
    burst(3'b001, 1'b0, 0, 72, 0);

    // Early RLAST.
    do_reset();
    req_len[0 +: 4] = 4'd3;
    burst(3'b001, 1'b0, 0, 0, 1);

    // Mismatched RID still routed to master 0.
    do_reset();
    burst(3'b001, 1'b0, 1, 0, 2);

    // Stray beat while idle.
    do_reset();
    RVALID = 1'b1;
    #1;
    check("stray_rready", 64'(RREADY), 64'(0));
    check("stray_resp_valid", 64'(resp_valid), 64'(0));
    tick();
    RVALID = 1'b0;
    check("stray_proto_err", 64'(proto_err), 64'(1));

    // Reset in the middle of a data phase, then all masters request.
    do_reset();
    req_len[0 +: 4] = 4'd3;
    burst(3'b001, 1'b0, 0, 0, 3);
    tick();
    rst_n   = 1'b1;
    last_g  = M - 1;
    exp_err = 1'b0;
    tick();
    burst(3'b111, 1'b0, 0, -1, 0);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < M; i++) req_len[i*4 +: 4] = 4'($urandom_range(0, 3));
      scramble_addr();
      data_base = $urandom;
      burst(M'($urandom_range(1, 7)), 1'b0, int'($urandom_range(0, 3)), -1, 0);
      repeat (int'($urandom_range(0, 2))) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axi_read_scheduler.md
Name: axi_read_scheduler

Overview:
Shares the single AXI read channel (AR/R) between the core's read masters: I-cache, D-cache and I-stream buffer. Sits between the read masters and the external AXI read port. Grants one burst at a time, drives the AR handshake, then steers R beats back to the granted master until RLAST. Tracks the beat count and flags protocol errors.

Parameters:
MASTERS, 3, number of read requesters; master i uses ARID = i.
ADDR_WIDTH, 26, byte-address width (`ADDR_WIDTH).
DATA_WIDTH, 32, beat width (`DATA_WIDTH).

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  MASTERS  per-master burst request
req_addr  in  MASTERS*ADDR_WIDTH  per-master start address; slice i belongs to master i
req_len  in  MASTERS*4  per-master ARLEN (beats-1)
req_ready  out  MASTERS  one-hot request accept pulse
resp_valid  out  MASTERS  one-hot beat strobe to the granted master
resp_last  out  MASTERS  one-hot last-beat strobe
resp_data  out  DATA_WIDTH  beat data, broadcast to all masters
ARVALID  out  1  AXI read address valid
ARREADY  in  1  AXI read address ready
ARID  out  4  granted master index
ARLEN  out  4  latched req_len
ARADDR  out  ADDR_WIDTH  latched req_addr
RVALID  in  1  AXI read data valid
RREADY  out  1  AXI read data ready
RLAST  in  1  AXI last beat
RID  in  4  AXI read id
RDATA  in  DATA_WIDTH  AXI read data
busy  out  1  state != IDLE
proto_err  out  1  sticky protocol error flag

Behaviour:
- Reset (async assert, sync release). State IDLE. ARVALID=0, RREADY=0. req_ready, resp_valid and resp_last all 0. proto_err=0. ARID, ARLEN and ARADDR are 0. Round-robin pointer last_grant = MASTERS-1, so master 0 is preferred first.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any req_valid is set, select master g by round-robin: the first set bit scanning from last_grant+1 modulo MASTERS.
  - In the same cycle, pulse req_ready[g]=1 for exactly one cycle.
  - Register ARADDR, ARLEN and ARID from master g's slices, set last_grant = g, clear beat_cnt, and go to ADDR.
  - Masters hold req_addr and req_len stable while req_valid is high and req_ready is low; after req_ready they may change them.
- ADDR: ARVALID=1 with stable ARADDR, ARLEN and ARID. When ARVALID && ARREADY, go to DATA. ARVALID drops the next cycle.
- Latency: req_valid seen in IDLE at cycle t → ARVALID=1 at t+1. If ARREADY is already high, the AR handshake completes at t+1.
- DATA:
  - RREADY=1 (combinational on state).
  - Each cycle with RVALID: resp_valid[ARID]=RVALID, resp_last[ARID]=RVALID&&RLAST, resp_data=RDATA. These are combinational pass-through, zero latency, and no other master sees a strobe. Increment 4-bit beat_cnt.
  - On RVALID&&RLAST, go to IDLE. A new grant is possible in the following cycle; there is no back-to-back grant in the RLAST cycle.
- resp_data = RDATA at all times; masters qualify it with resp_valid.
- proto_err, sticky until reset, is set by any of:
  - a beat with RID != ARID; the beat is still routed to ARID;
  - RLAST on a beat where beat_cnt != ARLEN (early or late last);
  - RVALID in IDLE or ADDR; RREADY stays 0, so that beat is not accepted.
- Only one burst is ever outstanding; no ID reordering is needed.
- Simultaneous requests from all masters are served in the order last_grant+1, +2, … . A master that stays requesting waits at most MASTERS-1 bursts.
- A master deasserting req_valid before req_ready is legal; that request is simply dropped from the search.
- Reset mid-burst: returns to IDLE immediately. Outstanding AXI beats are the memory model's responsibility; the bench resets both together.

Optional Feature:
READ_ARB_FIXED_PRIO_EN
- Defined: round-robin is replaced by fixed priority, lowest index wins. last_grant is still updated but ignored.
- Not defined: round-robin as above.
- All other timing is identical in both modes.

Test Plan:
- Single request: master 1 requests addr 0x0000400, len 3; ARREADY=1 → req_ready[1] pulse at t; ARVALID, ARID=1, ARLEN=3 at t+1; 4 beats 0xA0..0xA3 appear on resp_valid[1] only; resp_last[1] on 0xA3; busy drops the cycle after.
- Contention: all 3 masters hold req_valid, len 0, after reset → grants in order 0,1,2,0. Under READ_ARB_FIXED_PRIO_EN, grants are 0,0,0 while master 0 keeps requesting.
- AR backpressure: ARREADY held 0 for 5 cycles → ARVALID, ARADDR, ARLEN and ARID stay stable for 6 cycles; DATA is entered only after the handshake.
- R gaps: RVALID toggles 1,0,0,1,1,0,1 across a len-3 burst → exactly 4 resp_valid pulses, resp_last on the 4th, proto_err=0.
- Errors: RLAST on beat 2 of len 3 → proto_err=1 and state returns to IDLE. RID=2 while ARID=0 → proto_err=1 and the beat is routed to master 0. Stray RVALID in IDLE → RREADY=0 and proto_err=1.
- Reset mid-burst: assert rst_n=0 during DATA, beat 1 → all outputs return to reset values asynchronously; after release, master 0 is granted first.
